// File: rtl/cpu_control.sv
// ---------------------------------------------------------------------------
// cpu_control
//
// Multi-cycle fetch / decode / execute / writeback controller for the 8-bit
// CPU. It fetches a 16-bit instruction over a req/ack handshake, drives the
// register file read addresses, and latches the returned operands into A/B.
// It presents A/B to the external ALU, latches the ALU result, and issues a
// single-cycle register write in the writeback state.
//
// Instruction word fields:
//   op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm8 = [7:0]
//
// Opcodes:
//   1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR  : rd = rs1 op rs2
//   6 LDI                             : rd = imm8
//   7 MOV                             : rd = rs1
//   8 JMP                             : pc = imm8
//   9 BZ                              : if reg[rd] == 0 then pc = imm8
//   15 HLT                            : stop until reset
//   anything else                     : NOP
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous active-high reset
//   imem_req    out  1   instruction fetch request (high in FETCH only)
//   imem_ack    in   1   fetch accepted, imem_data valid this cycle
//   imem_addr   out  8   fetch address (always equal to pc)
//   imem_data   in   16  instruction word
//   read_reg1   out  3   register file read address, port 1
//   read_reg2   out  3   register file read address, port 2
//   read_data1  in   8   register file read data, port 1 (asynchronous)
//   read_data2  in   8   register file read data, port 2 (asynchronous)
//   alu_op      out  3   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
//   alu_a       out  8   ALU operand A (latched A register)
//   alu_b       out  8   ALU operand B (latched B register)
//   alu_result  in   8   combinational ALU result
//   reg_write   out  1   register file write strobe (one cycle per write)
//   write_reg   out  3   destination register
//   write_data  out  8   value to write
//   pc          out  8   program counter
//   halted      out  1   high once a HLT has completed writeback
// ---------------------------------------------------------------------------
module cpu_control (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    output logic [2:0]  read_reg1,
    output logic [2:0]  read_reg2,
    input  logic [7:0]  read_data1,
    input  logic [7:0]  read_data2,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_result,
    output logic        reg_write,
    output logic [2:0]  write_reg,
    output logic [7:0]  write_data,
    output logic [7:0]  pc,
    output logic        halted
);

    // Opcode values
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LDI = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_BZ  = 4'd9;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t state;
    state_t next_state;

    // Architectural registers of the controller
    logic [15:0] ir;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;

    // Instruction fields (imm8 overlaps rs1/rs2 by design of the encoding)
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm8;

    // Decoded instruction classes
    logic is_alu;
    logic is_ldi;
    logic is_mov;
    logic is_jmp;
    logic is_bz;
    logic is_hlt;
    logic writes_reg;
    logic branch_taken;

    assign op   = ir[15:12];
    assign rd   = ir[11:9];
    assign rs1  = ir[8:6];
    assign rs2  = ir[5:3];
    assign imm8 = ir[7:0];

    // Opcode classification; everything not listed falls through as a NOP
    always_comb begin
        is_alu = 1'b0;
        is_ldi = 1'b0;
        is_mov = 1'b0;
        is_jmp = 1'b0;
        is_bz  = 1'b0;
        is_hlt = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_alu = 1'b1;
            OP_LDI: is_ldi = 1'b1;
            OP_MOV: is_mov = 1'b1;
            OP_JMP: is_jmp = 1'b1;
            OP_BZ:  is_bz  = 1'b1;
            OP_HLT: is_hlt = 1'b1;
            OP_NOP: ;
            default: ;
        endcase
    end

    assign writes_reg = is_alu | is_ldi | is_mov;

    // BZ tests the operand latched in DECODE, which came from the rd field
    assign branch_taken = is_jmp | (is_bz & (a == 8'd0));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (imem_ack) next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC:   next_state = S_WB;
            S_WB:     next_state = is_hlt ? S_HALT : S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Datapath registers. pc increments on fetch acceptance and a taken
    // branch in WB overrides that already-incremented value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= 8'd0;
            ir  <= 16'd0;
            a   <= 8'd0;
            b   <= 8'd0;
            res <= 8'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                        pc <= pc + 8'd1;
                    end
                end
                S_DECODE: begin
                    a <= read_data1;
                    b <= read_data2;
                end
                S_EXEC: begin
                    res <= alu_result;
                end
                S_WB: begin
                    if (branch_taken) pc <= imm8;
                end
                default: ;
            endcase
        end
    end

    // Fetch interface and status outputs
    always_comb begin
        imem_req  = (state == S_FETCH);
        imem_addr = pc;
        halted    = (state == S_HALT);
    end

    // Register file read addresses are only meaningful in DECODE; BZ reads
    // its test register through port 1 using the rd field.
    always_comb begin
        read_reg1 = 3'd0;
        read_reg2 = 3'd0;
        if (state == S_DECODE) begin
            read_reg1 = is_bz ? rd : rs1;
            read_reg2 = rs2;
        end
    end

    // ALU interface follows ir/a/b continuously
    always_comb begin
        alu_a  = a;
        alu_b  = b;
        alu_op = 3'd0;
        if (is_alu) alu_op = op[2:0] - 3'd1;
    end

    // Writeback. The strobe is masked by rst so a reset landing in WB never
    // commits the instruction being discarded.
    always_comb begin
        reg_write  = 1'b0;
        write_reg  = 3'd0;
        write_data = 8'd0;
        if (state == S_WB) begin
            reg_write = writes_reg & ~rst;
            write_reg = rd;
            if (is_alu) begin
                write_data = res;
            end else if (is_ldi) begin
                write_data = imm8;
            end else if (is_mov) begin
                write_data = a;
            end
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// ---------------------------------------------------------------------------
// tb_cpu_control
//
// Directed testbench for cpu_control. Surrounds the controller with a
// 256-word instruction memory, an 8-entry register file (cleared on rst) and
// a behavioural ALU, then walks short programs cycle by cycle. Cycle 1 is
// the first cycle after the reset cycle; inputs change and outputs are
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [2:0]  read_reg1;
    logic [2:0]  read_reg2;
    logic [7:0]  read_data1;
    logic [7:0]  read_data2;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [7:0]  write_data;
    logic [7:0]  pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] imem [0:255];
    logic [7:0]  regs [0:7];

    always #5 clk = ~clk;

    cpu_control dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .pc         (pc),
        .halted     (halted)
    );

    // Instruction memory and register file read ports
    assign imem_data  = imem[imem_addr];
    assign read_data1 = regs[read_reg1];
    assign read_data2 = regs[read_reg2];

    // Register file write port
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
        end else if (reg_write) begin
            regs[write_reg] <= write_data;
        end
    end

    // Behavioural ALU
    always_comb begin
        alu_result = 8'd0;
        case (alu_op)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            default: alu_result = 8'd0;
        endcase
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    // One reset cycle; returns at the start of cycle 1
    task automatic do_reset;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_mem();
        imem[0] = 16'h6205;
        imem_ack = 1'b1;
        do_reset();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_imem_req: got %0h expected 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_imem_addr: got %0h expected 0", imem_addr); end
        checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %0h expected 0", pc); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_reg_write: got %0h expected 0", reg_write); end
        checks++; if (write_reg !== 3'd0 || write_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_write_port: got reg %0h data %0h expected 0 0", write_reg, write_data); end
        checks++; if (read_reg1 !== 3'd0 || read_reg2 !== 3'd0) begin errors++; $display("[TB] FAIL reset_read_regs: got %0h %0h expected 0 0", read_reg1, read_reg2); end
        checks++; if (alu_op !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin errors++; $display("[TB] FAIL reset_alu: got op %0h a %0h b %0h expected 0 0 0", alu_op, alu_a, alu_b); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %0h expected 0", halted); end
        // Run partway through an instruction, then reset again
        for (int c = 1; c <= 6; c++) next_cycle();
        checks++; if (pc !== 8'h02) begin errors++; $display("[TB] FAIL run_pc: got %0h expected 2", pc); end
        do_reset();
        checks++; if (pc !== 8'h00 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rereset_state: got pc %0h req %0h expected 0 1", pc, imem_req); end
    endtask

    // LDI r1,5; LDI r2,3; ADD r3,r1,r2 with imem_ack tied high
    task automatic test_add_program;
        logic exp_we;
        clear_mem();
        imem[0] = 16'h6205;
        imem[1] = 16'h6403;
        imem[2] = 16'h1650;
        imem_ack = 1'b1;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            exp_we = (c == 4 || c == 8 || c == 12);
            checks++; if (reg_write !== exp_we) begin errors++; $display("[TB] FAIL add_reg_write_c%0d: got %0h expected %0h", c, reg_write, exp_we); end
            if (c == 4) begin
                checks++; if (write_reg !== 3'd1 || write_data !== 8'd5) begin errors++; $display("[TB] FAIL add_wb1: got reg %0h data %0h expected 1 5", write_reg, write_data); end
            end
            if (c == 8) begin
                checks++; if (write_reg !== 3'd2 || write_data !== 8'd3) begin errors++; $display("[TB] FAIL add_wb2: got reg %0h data %0h expected 2 3", write_reg, write_data); end
            end
            if (c == 10) begin
                checks++; if (read_reg1 !== 3'd1 || read_reg2 !== 3'd2) begin errors++; $display("[TB] FAIL add_decode_regs: got %0h %0h expected 1 2", read_reg1, read_reg2); end
            end
            if (c == 11) begin
                checks++; if (alu_a !== 8'd5 || alu_b !== 8'd3 || alu_op !== 3'd0) begin errors++; $display("[TB] FAIL add_exec: got a %0h b %0h op %0h expected 5 3 0", alu_a, alu_b, alu_op); end
            end
            if (c == 12) begin
                checks++; if (write_reg !== 3'd3 || write_data !== 8'd8) begin errors++; $display("[TB] FAIL add_wb3: got reg %0h data %0h expected 3 8", write_reg, write_data); end
            end
            next_cycle();
        end
        checks++; if (pc !== 8'd3 || imem_addr !== 8'd3) begin errors++; $display("[TB] FAIL add_pc_after: got pc %0h addr %0h expected 3 3", pc, imem_addr); end
        checks++; if (regs[3] !== 8'd8) begin errors++; $display("[TB] FAIL add_r3: got %0h expected 8", regs[3]); end
    endtask

    // First fetch held off for 3 cycles
    task automatic test_ack_stall;
        logic [7:0] exp_pc;
        clear_mem();
        imem[0] = 16'h6205;
        imem_ack = 1'b0;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) imem_ack = 1'b1;
            exp_pc = (c <= 4) ? 8'd0 : 8'd1;
            if (c <= 4) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin errors++; $display("[TB] FAIL stall_fetch_c%0d: got req %0h addr %0h expected 1 0", c, imem_req, imem_addr); end
            end
            checks++; if (pc !== exp_pc) begin errors++; $display("[TB] FAIL stall_pc_c%0d: got %0h expected %0h", c, pc, exp_pc); end
            checks++; if (reg_write !== (c == 7)) begin errors++; $display("[TB] FAIL stall_reg_write_c%0d: got %0h expected %0h", c, reg_write, (c == 7)); end
            next_cycle();
        end
    endtask

    // BZ taken on a zero register, then not taken after LDI
    task automatic test_branch;
        clear_mem();
        imem[0] = 16'h9450;
        imem_ack = 1'b1;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                checks++; if (read_reg1 !== 3'd2 || read_reg2 !== 3'd2) begin errors++; $display("[TB] FAIL bz_decode_regs: got %0h %0h expected 2 2", read_reg1, read_reg2); end
            end
            if (c <= 4) begin
                checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL bz_taken_reg_write_c%0d: got %0h expected 0", c, reg_write); end
            end
            if (c == 5) begin
                checks++; if (imem_addr !== 8'h50 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL bz_taken_target: got addr %0h req %0h expected 50 1", imem_addr, imem_req); end
            end
            next_cycle();
        end

        clear_mem();
        imem[0] = 16'h6401;
        imem[1] = 16'h9450;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            checks++; if (reg_write !== (c == 4)) begin errors++; $display("[TB] FAIL bz_not_taken_reg_write_c%0d: got %0h expected %0h", c, reg_write, (c == 4)); end
            if (c == 9) begin
                checks++; if (imem_addr !== 8'h02) begin errors++; $display("[TB] FAIL bz_not_taken_addr: got %0h expected 2", imem_addr); end
            end
            next_cycle();
        end
    endtask

    // HLT at address 2, then recovery through reset
    task automatic test_halt;
        logic exp_req;
        logic exp_halt;
        clear_mem();
        imem[2] = 16'hF000;
        imem_ack = 1'b1;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            exp_halt = (c >= 13);
            exp_req  = (c < 13) && ((c % 4) == 1);
            checks++; if (halted !== exp_halt) begin errors++; $display("[TB] FAIL halt_halted_c%0d: got %0h expected %0h", c, halted, exp_halt); end
            checks++; if (imem_req !== exp_req) begin errors++; $display("[TB] FAIL halt_req_c%0d: got %0h expected %0h", c, imem_req, exp_req); end
            next_cycle();
        end
        do_reset();
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'd0) begin errors++; $display("[TB] FAIL halt_recover: got halted %0h req %0h addr %0h expected 0 1 0", halted, imem_req, imem_addr); end
        next_cycle();
        checks++; if (pc !== 8'd1) begin errors++; $display("[TB] FAIL halt_refetch_pc: got %0h expected 1", pc); end
    endtask

    // Reset during EXEC, during WB and during an accepted fetch
    task automatic test_reset_mid;
        clear_mem();
        imem[0] = 16'h6205;
        imem[1] = 16'h6403;
        imem[2] = 16'h1650;
        imem_ack = 1'b1;
        do_reset();
        for (int c = 1; c < 11; c++) next_cycle();
        checks++; if (alu_a !== 8'd5 || alu_b !== 8'd3) begin errors++; $display("[TB] FAIL rst_exec_operands: got %0h %0h expected 5 3", alu_a, alu_b); end
        do_reset();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_exec_no_write: got %0h expected 0", reg_write); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0 || pc !== 8'd0) begin errors++; $display("[TB] FAIL rst_exec_fetch: got req %0h addr %0h pc %0h expected 1 0 0", imem_req, imem_addr, pc); end

        for (int c = 1; c < 4; c++) next_cycle();
        checks++; if (reg_write !== 1'b1) begin errors++; $display("[TB] FAIL rst_wb_pre: got %0h expected 1", reg_write); end
        rst = 1'b1;
        #1;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_wb_masked: got %0h expected 0", reg_write); end
        next_cycle();
        rst = 1'b0;
        checks++; if (pc !== 8'd0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_wb_fetch: got pc %0h req %0h expected 0 1", pc, imem_req); end

        for (int c = 1; c < 5; c++) next_cycle();
        checks++; if (pc !== 8'd1 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_fetch_pre: got pc %0h req %0h expected 1 1", pc, imem_req); end
        do_reset();
        checks++; if (pc !== 8'd0 || imem_addr !== 8'd0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_fetch_discard: got pc %0h addr %0h req %0h expected 0 0 1", pc, imem_addr, imem_req); end
        next_cycle();
        checks++; if (pc !== 8'd1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_fetch_restart: got pc %0h req %0h expected 1 0", pc, imem_req); end
    endtask

    // JMP 0xFF then NOP at 0xFF wraps to 0; opcode 12 and 0 never write
    task automatic test_wrap_nop;
        clear_mem();
        imem[0]   = 16'h80FF;
        imem[255] = 16'h0000;
        imem_ack = 1'b1;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL wrap_reg_write_c%0d: got %0h expected 0", c, reg_write); end
            if (c == 5) begin
                checks++; if (imem_addr !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_jmp_target: got %0h expected ff", imem_addr); end
            end
            if (c == 6) begin
                checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL wrap_pc: got %0h expected 0", pc); end
            end
            if (c == 9) begin
                checks++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_refetch: got addr %0h req %0h expected 0 1", imem_addr, imem_req); end
            end
            next_cycle();
        end

        clear_mem();
        imem[0] = 16'hC7FF;
        imem[1] = 16'h0E3F;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL nop_reg_write_c%0d: got %0h expected 0", c, reg_write); end
            if (c == 3) begin
                checks++; if (alu_op !== 3'd0) begin errors++; $display("[TB] FAIL nop_alu_op: got %0h expected 0", alu_op); end
            end
            if (c == 9) begin
                checks++; if (imem_addr !== 8'h02) begin errors++; $display("[TB] FAIL nop_sequential: got %0h expected 2", imem_addr); end
            end
            next_cycle();
        end
    endtask

    // Back-to-back SUB/AND/OR/XOR/MOV after two LDIs
    task automatic test_back_to_back;
        logic [15:0] prog     [0:6];
        logic [2:0]  exp_reg  [0:6];
        logic [7:0]  exp_data [0:6];
        logic [2:0]  exp_op   [0:6];
        int k;
        int phase;
        prog     = '{16'h620C, 16'h640A, 16'h2650, 16'h3850, 16'h4A50, 16'h5C50, 16'h7E40};
        exp_reg  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        exp_data = '{8'h0C, 8'h0A, 8'h02, 8'h08, 8'h0E, 8'h06, 8'h0C};
        exp_op   = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        clear_mem();
        for (int i = 0; i < 7; i++) imem[i] = prog[i];
        imem_ack = 1'b1;
        do_reset();
        for (int c = 1; c <= 28; c++) begin
            k     = (c - 1) / 4;
            phase = (c - 1) % 4;
            if (phase == 2) begin
                checks++; if (alu_op !== exp_op[k]) begin errors++; $display("[TB] FAIL b2b_alu_op_%0d: got %0h expected %0h", k, alu_op, exp_op[k]); end
            end
            if (phase == 3) begin
                checks++; if (reg_write !== 1'b1 || write_reg !== exp_reg[k] || write_data !== exp_data[k]) begin errors++; $display("[TB] FAIL b2b_wb_%0d: got we %0h reg %0h data %0h expected 1 %0h %0h", k, reg_write, write_reg, write_data, exp_reg[k], exp_data[k]); end
            end else begin
                checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_write_c%0d: got %0h expected 0", c, reg_write); end
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_add_program();
        test_ack_stall();
        test_branch();
        test_halt();
        test_reset_mid();
        test_wrap_nop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cpu_control.md
# cpu_control

Multi-cycle fetch/decode/execute/writeback controller for the 8-bit CPU. Sits directly upstream of the register file. It fetches 16-bit instructions over a req/ack handshake and drives the register file's read addresses. It latches the returned operands, hands them to the external ALU, and issues the single-cycle register write.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch accepted; imem_data valid in the same cycle
- imem_addr  out  8  fetch address (= pc)
- imem_data  in  16  instruction word
- read_reg1, read_reg2  out  3  register file read addresses
- read_data1, read_data2  in  8  register file read data (asynchronous)
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- alu_a, alu_b  out  8  ALU operands (latched A, B)
- alu_result  in  8  ALU result (combinational)
- reg_write  out  1  register write strobe
- write_reg  out  3  destination register
- write_data  out  8  write value
- pc  out  8  program counter
- halted  out  1  HLT executed

## Operation
- Instruction word fields: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm8=[7:0].
- Opcodes:
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2; alu_op = op-1.
  - 6 LDI: rd = imm8.
  - 7 MOV: rd = rs1.
  - 8 JMP: pc = imm8.
  - 9 BZ: if reg[rd field] == 0 then pc = imm8.
  - 15 HLT.
  - 0 and all other values: NOP (no write, no branch).
- Internal registers: ir[15:0], a[7:0], b[7:0], res[7:0], pc[7:0], state.
- FSM states and transitions:
  - FETCH: imem_req=1. On imem_ack: ir <= imem_data, pc <= pc+1 (mod 256), go to DECODE. Otherwise stay with pc held.
  - DECODE: read_reg1 = rs1, except BZ, where read_reg1 = rd field. read_reg2 = rs2. a <= read_data1, b <= read_data2. Go to EXEC.
  - EXEC: alu_a=a, alu_b=b, alu_op from opcode. res <= alu_result. Go to WB.
  - WB: reg_write=1 only for opcodes 1–7. write_reg=rd. write_data is res (ALU ops), imm8 (LDI) or a (MOV). JMP sets pc <= imm8. BZ sets pc <= imm8 if a == 0. HLT goes to HALT; every other opcode goes to FETCH.
  - HALT: all strobes 0, halted=1. Stays in HALT until rst.
- Outputs decode from state and registers. reg_write is high only in WB. read_reg1/read_reg2 are 0 outside DECODE. alu_op, alu_a and alu_b reflect ir/a/b at all times.
- No read-after-write hazard: the write lands at the end of WB, and the next DECODE is at least 2 cycles later.

## Timing
- Reset values (cycle after rst sampled high):
  - state=FETCH, pc=0, ir=0, a=b=res=0
  - imem_req=1, imem_addr=0
  - reg_write=0, write_reg=0, write_data=0
  - read_reg1=read_reg2=0, alu_op=0, halted=0
- Instruction latency with imem_ack tied high: 4 cycles (FETCH, DECODE, EXEC, WB). The next FETCH starts in cycle 5.
- Each cycle of imem_ack low in FETCH adds one cycle. imem_req stays high and imem_addr stays stable.
- imem_ack outside FETCH is ignored.
- reg_write is exactly one cycle wide per writing instruction.
- pc increments at fetch acceptance: 0xFF wraps to 0x00. A branch in WB overrides the incremented value.
- rst in any state, including mid-fetch with imem_ack high and WB:
  - Next state is FETCH with pc=0.
  - No reg_write is issued in the cycle rst is high.
  - Any pending instruction is discarded.
- HLT: halted=1 from the cycle after WB. imem_req=0 from then on.

## Test plan
- Reset, imem_ack=1, program LDI r1,5; LDI r2,3; ADD r3,r1,r2; bench ALU model -> reg_write pulses in cycles 4, 8, 12. The third pulse has write_reg=3, write_data=8. pc=3 after cycle 12.
- Hold imem_ack low 3 cycles on the first fetch -> imem_req high and imem_addr=0 for 4 cycles. pc becomes 1 only on the ack cycle. WB shifts by 3 cycles.
- BZ with r0=0, imm8=0x10 -> next imem_addr=0x10. LDI r0,1 then BZ r0,0x10 -> next imem_addr is sequential. No reg_write for either BZ.
- HLT at address 2 -> halted=1 and imem_req=0 indefinitely. rst -> halted=0, fetch restarts at 0.
- rst asserted during EXEC of ADD r3,r1,r2 -> no reg_write occurs. Next cycle is FETCH with imem_addr=0.
- JMP 0xFF; NOP at 0xFF -> after the NOP, imem_addr wraps to 0x00. No reg_write for opcode 0 or opcode 12.
